// File: rtl/priority_arbiter_8.sv
// Purpose : arbitrates one shared resource among 8 requesters (fixed-priority or round-robin).
// Latency : request to grant is 1 cycle; at least one idle cycle always follows a release.
// Backpres: a grant is held with no preemption until done, a dropped request, or hold timeout.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   level requests, req[i] high while master i wants the resource
//   done       one-cycle release pulse from the current owner (ignored when idle)
//   rr_mode    0 = fixed priority (7 highest), 1 = round-robin; used only while idle
//   gnt[7:0]   one-hot grant, zero when idle
//   gnt_id     index of the owner, meaningful while gnt_valid is high
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse in the idle cycle after a timeout-only release
module priority_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Last cycle of a full-length hold; unused when MAX_HOLD is 0.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        owner;
  logic [2:0]        last_id;
  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  logic [2:0]        rr_start;
  logic [2:0]        search_idx;
  logic [2:0]        win_id;
  logic              win_any;
  logic              hold_hit;
  logic              release_now;

  // Winner search: descend from the start index with wrap, first set bit wins.
  // Round-robin starts just below the last winner so it gets lowest priority.
  always_comb begin
    rr_start   = rr_mode ? (last_id - 3'd1) : 3'd7;
    win_id     = 3'd0;
    win_any    = 1'b0;
    search_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      search_idx = rr_start - 3'(k);
      if (!win_any && req[search_idx]) begin
        win_any = 1'b1;
        win_id  = search_idx;
      end
    end
  end

  assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now = done || !req[owner] || hold_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_any)     state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Owner, rotation pointer, hold counter and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 3'd0;
      last_id   <= 3'd0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state == IDLE) begin
        hold_cnt <= '0;
        if (win_any) begin
          owner <= win_id;
        end
      end else if (release_now) begin
        last_id  <= owner;
        hold_cnt <= '0;
        // Only flag a release that the timeout alone caused.
        timeout_q <= hold_hit && !done && req[owner];
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Outputs decode from registers only, so there is no input-to-output path.
  always_comb begin
    gnt       = (state == GRANT) ? (8'd1 << owner) : 8'd0;
    gnt_valid = (state == GRANT);
    gnt_id    = owner;
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_priority_arbiter_8.sv
module tb_priority_arbiter_8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_age   = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;
  bit chk_en  = 1'b0;

  int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  priority_arbiter_8 #(.MAX_HOLD(MAXH), .HOLD_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // Build the search order from the rules and take the first requester in it.
  function automatic int pick(input logic [7:0] r, input logic rr, input int last);
    int order[$];
    int res;
    res = -1;
    for (int k = 1; k <= 8; k++) order.push_back(rr ? (last - k + 8) % 8 : 8 - k);
    foreach (order[j]) if (res < 0 && r[order[j]]) res = order[j];
    return res;
  endfunction

  // Model: m_age counts cycles the grant has been visible so far.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_age = 0; m_last = 0; m_to = 1'b0;
    end else if (m_busy) begin
      bit rel_drop, rel_to;
      rel_drop = !req[m_owner];
      rel_to   = (MAXH != 0) && (m_age == MAXH);
      if (done || rel_drop || rel_to) begin
        m_busy = 1'b0;
        m_last = m_owner;
        m_to   = rel_to && !done && !rel_drop;
      end else begin
        m_age++;
        m_to = 1'b0;
      end
    end else begin
      m_to = 1'b0;
      if (req != 8'd0) begin
        m_owner = pick(req, rr_mode, m_last);
        m_busy  = 1'b1;
        m_age   = 1;
      end
    end
  end

  // Compare process: every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_gnt", gnt, m_busy ? (8'd1 << m_owner) : 8'd0);
      check("model_gnt_valid", {7'd0, gnt_valid}, {7'd0, m_busy});
      if (m_busy) check("model_gnt_id", {5'd0, gnt_id}, 8'(m_owner));
      check("model_timeout", {7'd0, timeout}, {7'd0, m_to});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int r;
    int idx;
    rst_n = 1'b0; req = 8'hFF; done = 1'b0; rr_mode = 1'b0;
    #1 chk_en = 1'b1;

    // 1: reset with all requests high
    tick();
    check("rst_gnt", gnt, 8'h00);
    check("rst_valid", {7'd0, gnt_valid}, 8'h00);
    check("rst_timeout", {7'd0, timeout}, 8'h00);
    check("rst_gnt_id", {5'd0, gnt_id}, 8'h00);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_gnt", gnt, 8'h00);
    check("post_rst_valid", {7'd0, gnt_valid}, 8'h00);
    tick();
    check("first_grant", gnt, 8'h80);
    check("first_grant_id", {5'd0, gnt_id}, 8'd7);
    req = 8'h00;
    tick(); tick();

    // 2: fixed priority, done pulse with owner dropping its request
    rr_mode = 1'b0; req = 8'b0010_1001;
    tick();
    check("fix_gnt5", gnt, 8'h20);
    check("fix_id5", {5'd0, gnt_id}, 8'd5);
    done = 1'b1; req = 8'b0000_1001;
    tick();
    done = 1'b0;
    check("fix_gap", gnt, 8'h00);
    tick();
    check("fix_gnt3", gnt, 8'h08);
    check("fix_id3", {5'd0, gnt_id}, 8'd3);
    req = 8'h00;
    tick(); tick();

    // 3: round-robin rotation from reset
    apply_reset();
    rr_mode = 1'b1; req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_id", {5'd0, gnt_id}, 8'(exp_seq[i]));
      check("rr_valid", {7'd0, gnt_valid}, 8'h01);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("rr_gap", gnt, 8'h00);
    end
    req = 8'h00;
    tick(); tick();

    // 4: hold timeout
    rr_mode = 1'b0; req = 8'h04;
    for (int c = 0; c < MAXH; c++) begin
      tick();
      check("hold_gnt", gnt, 8'h04);
      check("hold_no_to", {7'd0, timeout}, 8'h00);
    end
    tick();
    check("to_gnt", gnt, 8'h00);
    check("to_pulse", {7'd0, timeout}, 8'h01);
    tick();
    check("to_regrant", gnt, 8'h04);
    check("to_regrant_id", {5'd0, gnt_id}, 8'd2);
    check("to_cleared", {7'd0, timeout}, 8'h00);
    req = 8'h00;
    tick(); tick();

    // 5: owner drops request; then done coinciding with timeout
    req = 8'h42;
    tick(); check("drop_gnt6a", gnt, 8'h40);
    tick(); check("drop_gnt6b", gnt, 8'h40);
    req = 8'h02;
    tick(); check("drop_gap", gnt, 8'h00);
    tick(); check("drop_gnt1", gnt, 8'h02);
    check("drop_id1", {5'd0, gnt_id}, 8'd1);
    tick(); tick(); tick();
    check("done_to_hold", gnt, 8'h02);
    done = 1'b1;
    tick();
    check("done_to_gnt", gnt, 8'h00);
    check("done_to_timeout", {7'd0, timeout}, 8'h00);
    done = 1'b0; req = 8'h00;
    tick();

    // 6: async reset mid-grant, then round-robin from last_id=0
    rr_mode = 1'b0; req = 8'h10;
    tick();
    check("arst_pre", gnt, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 8'h00);
    check("arst_valid", {7'd0, gnt_valid}, 8'h00);
    tick();
    rst_n = 1'b1; req = 8'h11; rr_mode = 1'b1;
    tick();
    check("arst_rr_id", {5'd0, gnt_id}, 8'd4);
    check("arst_rr_gnt", gnt, 8'h10);
    req = 8'h00;
    tick();

    // random phase against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      r = $urandom_range(0, 9);
      if (r < 2) begin
        req = 8'($urandom);
      end else if (r < 4) begin
        idx = $urandom_range(0, 7);
        req[idx] = ~req[idx];
      end
      done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
      end
    end
    req = 8'h00; done = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
